sme_tx: RTL and testbench

SME_TX -- requirements
Module: sme_tx

---
 rtl/sme_pkg.sv | 25 ++
 rtl/sme_tx_if.sv | 44 ++++
 rtl/sme_tx_buf.sv | 23 ++
 rtl/sme_tx.sv | 197 +++++++++++++++++++
 tb/tb_sme_tx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared FSM state type, character constants and sizing defaults for sme_tx.
// Rev 1.0
`default_nettype none
package sme_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND_STR = 3'd1,
    S_SEND_PAT = 3'd2,
    S_WAIT     = 3'd3,
    S_REPORT   = 3'd4
  } sme_state_t;

  localparam logic [7:0] c_CARET  = 8'h5E;
  localparam logic [7:0] c_DOLLAR = 8'h24;
  localparam logic [7:0] c_DOT    = 8'h2E;
  localparam logic [7:0] c_SPACE  = 8'h20;

  localparam int c_STR_MAX_DEF = 32;
  localparam int c_PAT_MAX_DEF = 8;
  localparam int c_IDX_W       = 5;

  // Last WAIT count before giving up: 255 cycles in WAIT in total.
  localparam logic [7:0] c_TMO_LAST = 8'd254;
endpackage
`default_nettype wire

// File: rtl/sme_tx_if.sv
// sme_tx_if: host/engine signal bundle for sme_tx; timeout exists only with SME_TX_TIMEOUT_EN.
// Rev 1.0
`default_nettype none
interface sme_tx_if;
  import sme_pkg::*;

  logic               wr_en;
  logic               wr_sel;
  logic [7:0]         wr_data;
  logic               clr;
  logic               start;
  logic               start_pat;
  logic [7:0]         chardata;
  logic               isstring;
  logic               ispattern;
  logic               valid;
  logic               match;
  logic [c_IDX_W-1:0] match_index;
  logic               busy;
  logic               done;
  logic               res_match;
  logic [c_IDX_W-1:0] res_index;
  logic               ovf;
`ifdef SME_TX_TIMEOUT_EN
  logic               timeout;
`endif

  modport master (
`ifdef SME_TX_TIMEOUT_EN
    input  timeout,
`endif
    output wr_en, wr_sel, wr_data, clr, start, start_pat, valid, match, match_index,
    input  chardata, isstring, ispattern, busy, done, res_match, res_index, ovf
  );

  modport slave (
`ifdef SME_TX_TIMEOUT_EN
    output timeout,
`endif
    input  wr_en, wr_sel, wr_data, clr, start, start_pat, valid, match, match_index,
    output chardata, isstring, ispattern, busy, done, res_match, res_index, ovf
  );
endinterface
`default_nettype wire

// File: rtl/sme_tx_buf.sv
// sme_tx_buf: character buffer with indexed write and asynchronous indexed read; storage is never reset.
// Rev 1.0
`default_nettype none
module sme_tx_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [7:0]    i_wdata,
  input  wire logic [AW-1:0] i_raddr,
  output logic [7:0]         o_rdata
);
  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/sme_tx.sv
// sme_tx: buffers a string and a pattern, streams them to a matching engine and reports its result.
// Rev 1.0 -- optional WAIT timeout enabled by defining SME_TX_TIMEOUT_EN.
`default_nettype none
module sme_tx
  import sme_pkg::*;
#(
  parameter int STR_MAX = c_STR_MAX_DEF,
  parameter int PAT_MAX = c_PAT_MAX_DEF
) (
  input wire logic clk,
  input wire logic reset,
  sme_tx_if.slave  bus
);
  localparam int c_MAXLEN = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int c_LW     = $clog2(c_MAXLEN + 1);
  localparam int c_SAW    = $clog2(STR_MAX);
  localparam int c_PAW    = $clog2(PAT_MAX);
  localparam logic [c_LW-1:0] c_STR_LIM = c_LW'(STR_MAX);
  localparam logic [c_LW-1:0] c_PAT_LIM = c_LW'(PAT_MAX);
  localparam logic [c_LW-1:0] c_ONE     = c_LW'(1);

  sme_state_t         r_state;
  logic [c_LW-1:0]    r_str_len;
  logic [c_LW-1:0]    r_pat_len;
  logic [c_LW-1:0]    r_idx;
  logic               r_ovf;
  logic [7:0]         r_chardata;
  logic               r_isstring;
  logic               r_ispattern;
  logic               r_busy;
  logic               r_done;
  logic               r_res_match;
  logic [c_IDX_W-1:0] r_res_index;
`ifdef SME_TX_TIMEOUT_EN
  logic [7:0]         r_tmo_cnt;
  logic               r_timeout;
`endif

  logic             w_idle;
  logic             w_wr_ok;
  logic             w_str_we;
  logic             w_pat_we;
  logic             w_wr_drop;
  logic             w_go;
  logic             w_go_str;
  logic [c_SAW-1:0] w_str_raddr;
  logic [c_PAW-1:0] w_pat_raddr;
  logic [7:0]       w_str_char;
  logic [7:0]       w_pat_char;

  assign w_idle    = (r_state == S_IDLE);
  assign w_wr_ok   = w_idle & bus.wr_en & ~bus.clr;
  assign w_str_we  = w_wr_ok & ~bus.wr_sel & (r_str_len < c_STR_LIM);
  assign w_pat_we  = w_wr_ok &  bus.wr_sel & (r_pat_len < c_PAT_LIM);
  assign w_wr_drop = w_wr_ok & (bus.wr_sel ? (r_pat_len >= c_PAT_LIM) : (r_str_len >= c_STR_LIM));
  assign w_go      = w_idle & ~bus.clr & (bus.start | bus.start_pat) & (r_pat_len != '0);
  assign w_go_str  = bus.start & (r_str_len != '0);

  // Each buffer presents entry 0 unless it is the one being streamed, so the
  // first character of a phase is ready on the cycle that phase is entered.
  assign w_str_raddr = (r_state == S_SEND_STR) ? r_idx[c_SAW-1:0] : '0;
  assign w_pat_raddr = (r_state == S_SEND_PAT) ? r_idx[c_PAW-1:0] : '0;

  sme_tx_buf #(.DEPTH(STR_MAX), .AW(c_SAW)) u_str_buf (
    .clk     (clk),
    .i_we    (w_str_we),
    .i_waddr (r_str_len[c_SAW-1:0]),
    .i_wdata (bus.wr_data),
    .i_raddr (w_str_raddr),
    .o_rdata (w_str_char)
  );

  sme_tx_buf #(.DEPTH(PAT_MAX), .AW(c_PAW)) u_pat_buf (
    .clk     (clk),
    .i_we    (w_pat_we),
    .i_waddr (r_pat_len[c_PAW-1:0]),
    .i_wdata (bus.wr_data),
    .i_raddr (w_pat_raddr),
    .o_rdata (w_pat_char)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_str_len   <= '0;
      r_pat_len   <= '0;
      r_idx       <= '0;
      r_ovf       <= 1'b0;
      r_chardata  <= 8'h00;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
`ifdef SME_TX_TIMEOUT_EN
      r_tmo_cnt   <= 8'd0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef SME_TX_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.clr) begin
            r_str_len <= '0;
            r_pat_len <= '0;
            r_ovf     <= 1'b0;
          end else begin
            if (w_str_we)  r_str_len <= r_str_len + c_ONE;
            if (w_pat_we)  r_pat_len <= r_pat_len + c_ONE;
            if (w_wr_drop) r_ovf     <= 1'b1;
            if (w_go) begin
              r_busy <= 1'b1;
              r_idx  <= c_ONE;
              if (w_go_str) begin
                r_state    <= S_SEND_STR;
                r_chardata <= w_str_char;
                r_isstring <= 1'b1;
              end else begin
                r_state     <= S_SEND_PAT;
                r_chardata  <= w_pat_char;
                r_ispattern <= 1'b1;
              end
            end
          end
        end
        S_SEND_STR: begin
          if (r_idx == r_str_len) begin
            r_state     <= S_SEND_PAT;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b1;
            r_chardata  <= w_pat_char;
            r_idx       <= c_ONE;
          end else begin
            r_chardata <= w_str_char;
            r_idx      <= r_idx + c_ONE;
          end
        end
        S_SEND_PAT: begin
          if (r_idx == r_pat_len) begin
            r_state     <= S_WAIT;
            r_ispattern <= 1'b0;
            r_chardata  <= 8'h00;
`ifdef SME_TX_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
`endif
          end else begin
            r_chardata <= w_pat_char;
            r_idx      <= r_idx + c_ONE;
          end
        end
        S_WAIT: begin
          if (bus.valid) begin
            r_res_match <= bus.match;
            r_res_index <= bus.match_index;
            r_done      <= 1'b1;
            r_state     <= S_REPORT;
`ifdef SME_TX_TIMEOUT_EN
          end else if (r_tmo_cnt == c_TMO_LAST) begin
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_done      <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= S_REPORT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
`endif
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.chardata  = r_chardata;
  assign bus.isstring  = r_isstring;
  assign bus.ispattern = r_ispattern;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_match = r_res_match;
  assign bus.res_index = r_res_index;
  assign bus.ovf       = r_ovf;
`ifdef SME_TX_TIMEOUT_EN
  assign bus.timeout   = r_timeout;
`endif
endmodule
`default_nettype wire

// File: tb/tb_sme_tx.sv
// tb_sme_tx: table-driven, directed and randomized checks of sme_tx against a queue-based model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none
module tb_sme_tx;
  import sme_pkg::*;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sme_tx_if bus();

  sme_tx #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: buffer contents as queues plus the sticky overflow flag.
  logic [7:0] m_str[$];
  logic [7:0] m_pat[$];
  bit         m_ovf;

  typedef struct {
    bit         wr_en;
    bit         wr_sel;
    logic [7:0] data;
    bit         clr;
    bit         start;
    bit         exp_ovf;
    bit         exp_busy;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input bit sel, input logic [7:0] d);
    if (!sel) begin
      if (m_str.size() < STR_MAX) m_str.push_back(d); else m_ovf = 1'b1;
    end else begin
      if (m_pat.size() < PAT_MAX) m_pat.push_back(d); else m_ovf = 1'b1;
    end
  endtask

  task automatic do_write(input bit sel, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    m_write(sel, d);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    m_str.delete(); m_pat.delete(); m_ovf = 1'b0;
  endtask

  task automatic quiet_inputs();
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 8'h00; bus.clr = 0;
    bus.start = 0; bus.start_pat = 0; bus.valid = 0; bus.match = 0; bus.match_index = '0;
  endtask

  // One full transaction; expected streams come straight from the model queues.
  task automatic run_txn(input bit use_start, input bit use_pat, input bit noise, input int dly,
                         input bit vm, input logic [4:0] vi, input string tag);
    logic [7:0] exp_s[$];
    logic [7:0] exp_p[$];
    logic [7:0] got_s[$];
    logic [7:0] got_p[$];
    int cyc = 0;
    int bad = 0;
    exp_p = m_pat;
    if (use_start) exp_s = m_str;
    bus.start = use_start; bus.start_pat = use_pat;
    tick();
    bus.start = 0; bus.start_pat = 0;
    while ((bus.isstring || bus.ispattern) && cyc < 100) begin
      if (bus.isstring && bus.ispattern) bad++;
      if (!bus.busy) bad++;
      if (bus.isstring) begin
        if (got_p.size() != 0) bad++;
        got_s.push_back(bus.chardata);
      end else begin
        got_p.push_back(bus.chardata);
      end
      if (noise) begin
        bus.wr_en = 1; bus.wr_sel = cyc[0]; bus.wr_data = 8'hEE; bus.clr = 1;
        bus.start = 1; bus.start_pat = 1; bus.valid = 1; bus.match = 1; bus.match_index = 5'h1F;
      end
      tick();
      cyc++;
    end
    quiet_inputs();
    check({tag, " nstr"}, got_s.size(), exp_s.size());
    check({tag, " npat"}, got_p.size(), exp_p.size());
    foreach (got_s[i]) if (i < exp_s.size() && got_s[i] !== exp_s[i]) bad++;
    foreach (got_p[i]) if (i < exp_p.size() && got_p[i] !== exp_p[i]) bad++;
    for (int i = 0; i < dly; i++) begin
      if (bus.isstring || bus.ispattern || bus.chardata != 8'h00 || bus.done || !bus.busy) bad++;
      tick();
    end
    check({tag, " stream_errs"}, bad, 0);
    check({tag, " wait_busy"}, bus.busy, 1);
    check({tag, " wait_quals"}, {bus.isstring, bus.ispattern, bus.chardata}, 0);
    bus.valid = 1; bus.match = vm; bus.match_index = vi;
    tick();
    bus.valid = 0; bus.match = 0; bus.match_index = '0;
    check({tag, " done"}, bus.done, 1);
    check({tag, " res_match"}, bus.res_match, vm);
    check({tag, " res_index"}, bus.res_index, vi);
    tick();
    check({tag, " done_1cyc"}, bus.done, 0);
    check({tag, " idle_busy"}, bus.busy, 0);
    check({tag, " res_hold"}, {bus.res_match, bus.res_index}, {vm, vi});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    string s;
    int cyc;
    int bad;
    int sel;

    vt[0]  = '{0, 0, 8'h00, 1, 0, 0, 0};
    vt[1]  = '{0, 0, 8'h00, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) vt[2+i] = '{1, 1, 8'(8'h61 + i), 0, 0, 0, 0};
    vt[10] = '{1, 1, 8'h7A, 0, 0, 1, 0};
    vt[11] = '{1, 0, 8'h73, 0, 0, 1, 0};
    vt[12] = '{1, 0, 8'h74, 1, 0, 0, 0};
    vt[13] = '{0, 0, 8'h00, 0, 1, 0, 0};

    quiet_inputs();
    reset = 1'b0;
    #12;
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst ovf", bus.ovf, 0);
    check("rst isstring", bus.isstring, 0);
    check("rst ispattern", bus.ispattern, 0);
    check("rst chardata", bus.chardata, 0);
    check("rst res_match", bus.res_match, 0);
    check("rst res_index", bus.res_index, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    foreach (vt[i]) begin
      bus.wr_en = vt[i].wr_en; bus.wr_sel = vt[i].wr_sel; bus.wr_data = vt[i].data;
      bus.clr = vt[i].clr; bus.start = vt[i].start;
      tick();
      quiet_inputs();
      if (vt[i].clr) begin m_str.delete(); m_pat.delete(); m_ovf = 0; end
      else if (vt[i].wr_en) m_write(vt[i].wr_sel, vt[i].data);
      check($sformatf("vec%0d ovf", i), bus.ovf, vt[i].exp_ovf);
      check($sformatf("vec%0d busy", i), bus.busy, vt[i].exp_busy);
    end

    // Basic string + pattern transaction, then an identical resend.
    do_clr();
    s = "abc d";
    foreach (s[i]) do_write(0, s[i]);
    do_write(1, c_CARET);
    do_write(1, 8'h64);
    run_txn(1, 0, 0, 2, 1, 5'd4, "basic");
    run_txn(1, 0, 0, 0, 1, 5'd4, "resend");

    // Pattern-only transaction.
    do_clr();
    do_write(1, 8'h78);
    run_txn(0, 1, 0, 0, 0, 5'd7, "patonly");

    // String overflow at capacity.
    do_clr();
    for (int i = 0; i < 33; i++) do_write(0, 8'($urandom_range(32, 126)));
    check("ovf set", bus.ovf, 1);
    do_write(1, c_DOLLAR);
    run_txn(1, 0, 0, 1, 1, 5'd31, "full");
    do_clr();
    check("ovf cleared", bus.ovf, 0);

    // Inputs toggled while sending must not disturb lengths or the result.
    do_write(1, c_DOT);
    bus.start = 1;
    tick();
    bus.start = 0;
    check("nostr first pat", {bus.isstring, bus.ispattern, bus.chardata}, {2'b01, c_DOT});
    tick();
    bus.valid = 1; bus.match = 1; bus.match_index = 5'd2;
    tick();
    quiet_inputs();
    tick();
    do_clr();
    s = "hi";
    foreach (s[i]) do_write(0, s[i]);
    do_write(1, c_SPACE);
    run_txn(1, 0, 1, 1, 0, 5'd9, "noise");
    run_txn(1, 0, 0, 0, 1, 5'd3, "after_noise");

    // Reset in the middle of the pattern phase.
    bus.start = 1;
    tick();
    bus.start = 0;
    cyc = 0;
    while (!bus.ispattern && cyc < 20) begin tick(); cyc++; end
    check("reached pattern", bus.ispattern, 1);
    reset = 1'b0;
    #1;
    check("abort quals", {bus.isstring, bus.ispattern}, 0);
    check("abort busy", bus.busy, 0);
    #3;
    reset = 1'b1;
    m_str.delete(); m_pat.delete(); m_ovf = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.busy) bad++;
    end
    check("no done after abort", bad, 0);
    bus.start_pat = 1;
    tick();
    bus.start_pat = 0;
    check("empty start_pat ignored", bus.busy, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) do_clr();
      for (int k = 0; k < int'($urandom_range(0, 6)); k++)
        do_write($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)));
      check($sformatf("rnd%0d ovf", it), bus.ovf, m_ovf);
      if (m_pat.size() > 0) begin
        sel = int'($urandom_range(0, 2));
        run_txn(sel != 1, sel != 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 4)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", it));
      end
    end

`ifdef SME_TX_TIMEOUT_EN
    do_clr();
    do_write(1, c_DOT);
    run_txn(0, 1, 0, 0, 1, 5'd9, "pre_tmo");
    bus.start_pat = 1;
    tick();
    bus.start_pat = 0;
    cyc = 0;
    while (bus.ispattern && cyc < 10) begin tick(); cyc++; end
    cyc = 0;
    while (!bus.done && cyc < 400) begin tick(); cyc++; end
    check("tmo cycles", cyc, 255);
    check("tmo flag", bus.timeout, 1);
    check("tmo res", {bus.res_match, bus.res_index}, 0);
    tick();
    check("tmo pulse", {bus.timeout, bus.done, bus.busy}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
